// File: rtl/reorder_buffer_pkg.sv
// Shared configuration for the reorder buffer: sizing and entry type codes.
package reorder_buffer_pkg;

    localparam int ROB_SIZE_BIT = 3;
    localparam int ROB_TYPE_BIT = 2;

    localparam logic [ROB_TYPE_BIT-1:0] ROB_REG = 2'd0;
    localparam logic [ROB_TYPE_BIT-1:0] ROB_BR  = 2'd1;
    localparam logic [ROB_TYPE_BIT-1:0] ROB_ST  = 2'd2;
    localparam logic [ROB_TYPE_BIT-1:0] ROB_LD  = 2'd3;

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order issue, CDB writeback with operand bypass,
// in-order commit to the register file / LSB and branch-mispredict flush.
module reorder_buffer
    import reorder_buffer_pkg::ROB_REG, reorder_buffer_pkg::ROB_BR,
           reorder_buffer_pkg::ROB_ST, reorder_buffer_pkg::ROB_LD;
#(
    parameter int ROB_SIZE_BIT = reorder_buffer_pkg::ROB_SIZE_BIT,
    parameter int ROB_TYPE_BIT = reorder_buffer_pkg::ROB_TYPE_BIT
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    issue_valid,
    input  logic                    issue_fi,
    input  logic [31:0]             issue_value,
    input  logic [31:0]             issue_addr,
    input  logic [ROB_TYPE_BIT-1:0] issue_type,
    input  logic [4:0]              issue_rd,
    output logic                    rob_full,
    output logic [ROB_SIZE_BIT-1:0] rob_vacant_id,
    output logic                    rob_clear,
    input  logic [ROB_SIZE_BIT-1:0] qry1_id,
    input  logic [ROB_SIZE_BIT-1:0] qry2_id,
    output logic                    qry1_fi,
    output logic                    qry2_fi,
    output logic [31:0]             qry1_value,
    output logic [31:0]             qry2_value,
    input  logic                    cdb_valid,
    input  logic [ROB_SIZE_BIT-1:0] cdb_rob_id,
    input  logic [31:0]             cdb_value,
    output logic                    commit_reg_valid,
    output logic [4:0]              commit_reg_id,
    output logic [31:0]             commit_reg_value,
    output logic [ROB_SIZE_BIT-1:0] commit_rob_id,
    output logic                    store_commit,
    output logic                    set_pc_valid,
    output logic [31:0]             set_pc_value
);

    localparam int ROB_ENTRIES = 1 << ROB_SIZE_BIT;
    localparam logic [ROB_SIZE_BIT-1:0] PTR_ONE   = {{(ROB_SIZE_BIT-1){1'b0}}, 1'b1};
    localparam logic [ROB_SIZE_BIT:0]   CNT_ONE   = {{ROB_SIZE_BIT{1'b0}}, 1'b1};
    localparam logic [ROB_SIZE_BIT:0]   LAST_FREE = {1'b0, {ROB_SIZE_BIT{1'b1}}};

    logic [ROB_SIZE_BIT-1:0] head_r;
    logic [ROB_SIZE_BIT-1:0] tail_r;
    logic [ROB_SIZE_BIT:0]   count_r;
    logic [ROB_ENTRIES-1:0]  busy_r;
    logic [ROB_ENTRIES-1:0]  ready_r;
    logic [ROB_TYPE_BIT-1:0] type_r      [ROB_ENTRIES];
    logic [4:0]              rd_r        [ROB_ENTRIES];
    logic [31:0]             value_r     [ROB_ENTRIES];
    logic [31:0]             actual_pc_r [ROB_ENTRIES];
    logic [31:0]             addr_r      [ROB_ENTRIES];

    logic head_commit_s;
    logic flush_s;
    logic issue_en_s;
    logic cdb_en_s;
    logic unused_addr_s;

    assign head_commit_s = busy_r[head_r] && ready_r[head_r];
    assign flush_s       = head_commit_s && (type_r[head_r] == ROB_BR)
                           && (actual_pc_r[head_r] != value_r[head_r]);
    // A full buffer drops the issue rather than overwriting the head entry.
    assign issue_en_s    = issue_valid && !rob_clear && !flush_s && !count_r[ROB_SIZE_BIT];
    assign cdb_en_s      = cdb_valid && !rob_clear && !flush_s
                           && busy_r[cdb_rob_id] && !ready_r[cdb_rob_id];
    assign unused_addr_s = ^addr_r[head_r];

    // The decoder samples these a cycle ahead, so the in-flight issue is counted.
    assign rob_full      = count_r[ROB_SIZE_BIT] || (issue_valid && (count_r == LAST_FREE));
    assign rob_vacant_id = tail_r + {{(ROB_SIZE_BIT-1){1'b0}}, issue_valid};

    // Operand query 1: stored result first, then same-cycle CDB bypass.
    always_comb begin
        qry1_fi    = 1'b0;
        qry1_value = 32'd0;
        if (ready_r[qry1_id]) begin
            qry1_fi    = 1'b1;
            qry1_value = value_r[qry1_id];
        end else if (cdb_valid && (cdb_rob_id == qry1_id)) begin
            qry1_fi    = 1'b1;
            qry1_value = cdb_value;
        end else begin
            qry1_fi    = 1'b0;
            qry1_value = 32'd0;
        end
    end

    // Operand query 2: stored result first, then same-cycle CDB bypass.
    always_comb begin
        qry2_fi    = 1'b0;
        qry2_value = 32'd0;
        if (ready_r[qry2_id]) begin
            qry2_fi    = 1'b1;
            qry2_value = value_r[qry2_id];
        end else if (cdb_valid && (cdb_rob_id == qry2_id)) begin
            qry2_fi    = 1'b1;
            qry2_value = cdb_value;
        end else begin
            qry2_fi    = 1'b0;
            qry2_value = 32'd0;
        end
    end

    // Entry storage, pointers, and registered commit/flush outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head_r           <= '0;
            tail_r           <= '0;
            count_r          <= '0;
            busy_r           <= '0;
            ready_r          <= '0;
            rob_clear        <= 1'b0;
            commit_reg_valid <= 1'b0;
            commit_reg_id    <= 5'd0;
            commit_reg_value <= 32'd0;
            commit_rob_id    <= '0;
            store_commit     <= 1'b0;
            set_pc_valid     <= 1'b0;
            set_pc_value     <= 32'd0;
            for (int i = 0; i < ROB_ENTRIES; i++) begin
                type_r[i]      <= '0;
                rd_r[i]        <= 5'd0;
                value_r[i]     <= 32'd0;
                actual_pc_r[i] <= 32'd0;
                addr_r[i]      <= 32'd0;
            end
        end else if (!rdy_in) begin
            rob_clear        <= 1'b0;
            commit_reg_valid <= 1'b0;
            store_commit     <= 1'b0;
            set_pc_valid     <= 1'b0;
        end else begin
            rob_clear        <= 1'b0;
            commit_reg_valid <= 1'b0;
            store_commit     <= 1'b0;
            set_pc_valid     <= 1'b0;
            if (flush_s) begin
                head_r       <= '0;
                tail_r       <= '0;
                count_r      <= '0;
                busy_r       <= '0;
                ready_r      <= '0;
                rob_clear    <= 1'b1;
                set_pc_valid <= 1'b1;
                set_pc_value <= actual_pc_r[head_r];
            end else begin
                if (head_commit_s) begin
                    busy_r[head_r]  <= 1'b0;
                    ready_r[head_r] <= 1'b0;
                    head_r          <= head_r + PTR_ONE;
                    case (type_r[head_r])
                        ROB_REG, ROB_LD: begin
                            commit_reg_valid <= 1'b1;
                            commit_reg_id    <= rd_r[head_r];
                            commit_reg_value <= value_r[head_r];
                            commit_rob_id    <= head_r;
                        end
                        ROB_ST: begin
                            store_commit  <= 1'b1;
                            commit_rob_id <= head_r;
                        end
                        ROB_BR:  ;
                        default: ;
                    endcase
                end
                if (issue_en_s) begin
                    busy_r[tail_r]      <= 1'b1;
                    ready_r[tail_r]     <= issue_fi;
                    type_r[tail_r]      <= issue_type;
                    rd_r[tail_r]        <= issue_rd;
                    value_r[tail_r]     <= issue_value;
                    actual_pc_r[tail_r] <= issue_value;
                    addr_r[tail_r]      <= issue_addr;
                    tail_r              <= tail_r + PTR_ONE;
                end
                if (cdb_en_s) begin
                    ready_r[cdb_rob_id] <= 1'b1;
                    case (type_r[cdb_rob_id])
                        ROB_REG, ROB_LD: value_r[cdb_rob_id]     <= cdb_value;
                        ROB_BR:          actual_pc_r[cdb_rob_id] <= cdb_value;
                        ROB_ST:          ;
                        default:         ;
                    endcase
                end
                case ({issue_en_s, head_commit_s})
                    2'b10:   count_r <= count_r + CNT_ONE;
                    2'b01:   count_r <= count_r - CNT_ONE;
                    default: count_r <= count_r;
                endcase
            end
        end
    end

endmodule
